// File: rtl/res_station_pkg.sv
// Shared Tomasulo types for the reservation station:
// ROB tags, RS states, CDB bundle and the dispatched control word.
package res_station_pkg;

  localparam int TAG_W = 3;
  localparam int XLEN  = 32;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_WAIT,
    RS_READY
  } rs_state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

  typedef struct packed {
    logic            valid;
    rob_tag_t        tag;
    logic [XLEN-1:0] data;
  } cdb_t;

  typedef struct packed {
    alu_op_t         op;
    logic [4:0]      src1_reg;
    logic            src1_valid;
    logic [4:0]      src2_reg;
    logic            src2_valid;
    logic [XLEN-1:0] src2_data;
    logic [2:0]      funct3;
    logic            funct7;
    logic [XLEN-1:0] pc;
  } ctl_word_t;

  function automatic logic tag_hit(cdb_t c, rob_tag_t t);
    return c.valid && (c.tag == t);
  endfunction

endpackage

// File: rtl/res_station_operand.sv
// One source-operand slot of a reservation station:
// load-time init from regfile/immediate, CDB bypass and snoop.
import res_station_pkg::*;

module rs_operand (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic            snoop,
  input  logic            use_reg,
  input  logic [XLEN-1:0] imm,
  input  logic            rf_ready,
  input  logic [XLEN-1:0] rf_data,
  input  rob_tag_t        rf_tag,
  input  cdb_t            cdb,
  output logic            ready_nxt,
  output logic            ready,
  output logic [XLEN-1:0] value
);

  logic            valid_q, valid_n;
  rob_tag_t        tag_q, tag_n;
  logic [XLEN-1:0] data_q, data_n;

  // Next operand contents: init on load, otherwise capture a matching broadcast.
  always_comb begin
    valid_n = valid_q;
    tag_n   = tag_q;
    data_n  = data_q;
    if (load) begin
      valid_n = 1'b1;
      tag_n   = '0;
      data_n  = '0;
      if (!use_reg) begin
        data_n = imm;
      end else if (rf_ready) begin
        data_n = rf_data;
      end else if (tag_hit(cdb, rf_tag)) begin
        data_n = cdb.data;
      end else begin
        valid_n = 1'b0;
        tag_n   = rf_tag;
      end
    end else if (snoop && !valid_q && tag_hit(cdb, tag_q)) begin
      valid_n = 1'b1;
      data_n  = cdb.data;
    end
  end

  // Operand registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_n;
      tag_q   <= tag_n;
      data_q  <= data_n;
    end
  end

  assign ready_nxt = valid_n;
  assign ready     = valid_q;
  assign value     = data_q;

endmodule

// File: rtl/res_station.sv
// Single Tomasulo reservation-station entry:
// holds one dispatched instruction until both operands are known, then issues.
import res_station_pkg::*;

module res_station #(
  parameter int TAG_W = res_station_pkg::TAG_W,
  parameter int XLEN  = res_station_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  ctl_word_t        ctl_i,
  input  logic [TAG_W-1:0] rob_tag_i,
  input  logic             rf1_ready,
  input  logic [XLEN-1:0]  rf1_data,
  input  logic [TAG_W-1:0] rf1_tag,
  input  logic             rf2_ready,
  input  logic [XLEN-1:0]  rf2_data,
  input  logic [TAG_W-1:0] rf2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  input  logic             fu_ready,
  output logic             res_empty,
  output logic             fu_valid,
  output alu_op_t          fu_op,
  output logic [2:0]       fu_funct3,
  output logic             fu_funct7,
  output logic [XLEN-1:0]  fu_a,
  output logic [XLEN-1:0]  fu_b,
  output logic [TAG_W-1:0] fu_tag
);

  rs_state_t        state_q, state_n;
  ctl_word_t        ctl_q;
  logic [TAG_W-1:0] tag_q;
  cdb_t             cdb;
  logic             clr, take, snoop;
  logic             r1_nxt, r2_nxt;
  logic             r1, r2;

  assign cdb   = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};
  assign clr   = rst | flush;
  assign take  = load && (state_q == RS_IDLE);
  assign snoop = (state_q == RS_WAIT);

  rs_operand u_op1 (
    .clk       (clk),
    .clr       (clr),
    .load      (take),
    .snoop     (snoop),
    .use_reg   (ctl_i.src1_valid),
    .imm       ('0),
    .rf_ready  (rf1_ready),
    .rf_data   (rf1_data),
    .rf_tag    (rf1_tag),
    .cdb       (cdb),
    .ready_nxt (r1_nxt),
    .ready     (r1),
    .value     (fu_a)
  );

  rs_operand u_op2 (
    .clk       (clk),
    .clr       (clr),
    .load      (take),
    .snoop     (snoop),
    .use_reg   (ctl_i.src2_valid),
    .imm       (ctl_i.src2_data),
    .rf_ready  (rf2_ready),
    .rf_data   (rf2_data),
    .rf_tag    (rf2_tag),
    .cdb       (cdb),
    .ready_nxt (r2_nxt),
    .ready     (r2),
    .value     (fu_b)
  );

  // State register; flush has the same effect as reset.
  always_ff @(posedge clk) begin
    if (clr) state_q <= RS_IDLE;
    else     state_q <= state_n;
  end

  // Next state from the operand slots' next-cycle readiness.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      RS_IDLE:
        if (load) state_n = (r1_nxt && r2_nxt) ? RS_READY : RS_WAIT;
      RS_WAIT:
        if (r1_nxt && r2_nxt) state_n = RS_READY;
      RS_READY:
        if (fu_ready) state_n = RS_IDLE;
      default:
        state_n = RS_IDLE;
    endcase
  end

  // Control word and destination tag latch, captured only on an accepted load.
  always_ff @(posedge clk) begin
    if (clr) begin
      ctl_q <= '0;
      tag_q <= '0;
    end else if (take) begin
      ctl_q <= ctl_i;
      tag_q <= rob_tag_i;
    end
  end

  assign res_empty = (state_q == RS_IDLE);
  assign fu_valid  = (state_q == RS_READY);
  assign fu_op     = ctl_q.op;
  assign fu_funct3 = ctl_q.funct3;
  assign fu_funct7 = ctl_q.funct7;
  assign fu_tag    = tag_q;

  logic unused;
  assign unused = ^{r1, r2, ctl_q.src1_reg, ctl_q.src2_reg, ctl_q.pc,
                    ctl_q.src1_valid, ctl_q.src2_valid, ctl_q.src2_data};

endmodule

// File: tb/tb_res_station.sv
// Self-checking bench for res_station: directed scenarios
// followed by random traffic against a transaction-level model.
import res_station_pkg::*;

module tb_res_station;

  logic            clk = 1'b0;
  logic            rst, flush, load;
  ctl_word_t       ctl_i;
  logic [2:0]      rob_tag_i;
  logic            rf1_ready, rf2_ready;
  logic [31:0]     rf1_data, rf2_data;
  logic [2:0]      rf1_tag, rf2_tag;
  logic            cdb_valid;
  logic [2:0]      cdb_tag;
  logic [31:0]     cdb_data;
  logic            fu_ready;
  logic            res_empty, fu_valid;
  alu_op_t         fu_op;
  logic [2:0]      fu_funct3;
  logic            fu_funct7;
  logic [31:0]     fu_a, fu_b;
  logic [2:0]      fu_tag;

  int n_cmp = 0;
  int n_err = 0;

  // Model: an entry is either free or holds one instruction whose
  // operands are each "known with value" or "awaiting a tag".
  bit          m_busy;
  bit          m_ha, m_hb;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ta, m_tb, m_tag;
  ctl_word_t   m_ctl;

  always #5 clk = ~clk;

  res_station dut (
    .clk(clk), .rst(rst), .flush(flush), .load(load),
    .ctl_i(ctl_i), .rob_tag_i(rob_tag_i),
    .rf1_ready(rf1_ready), .rf1_data(rf1_data), .rf1_tag(rf1_tag),
    .rf2_ready(rf2_ready), .rf2_data(rf2_data), .rf2_tag(rf2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_ready(fu_ready), .res_empty(res_empty), .fu_valid(fu_valid),
    .fu_op(fu_op), .fu_funct3(fu_funct3), .fu_funct7(fu_funct7),
    .fu_a(fu_a), .fu_b(fu_b), .fu_tag(fu_tag)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_in();
    rst = 0; flush = 0; load = 0; fu_ready = 0;
    ctl_i = '0; rob_tag_i = 0;
    rf1_ready = 0; rf1_data = 0; rf1_tag = 0;
    rf2_ready = 0; rf2_data = 0; rf2_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic model_update();
    bit hit_a, hit_b;
    if (rst || flush) begin
      m_busy = 0; m_ha = 0; m_hb = 0;
      m_a = 0; m_b = 0; m_ta = 0; m_tb = 0; m_tag = 0; m_ctl = '0;
    end else if (!m_busy) begin
      if (load) begin
        m_busy = 1; m_ctl = ctl_i; m_tag = rob_tag_i;
        m_ha = 1; m_a = 0;
        if (ctl_i.src1_valid) begin
          if (rf1_ready) m_a = rf1_data;
          else if (cdb_valid && cdb_tag == rf1_tag) m_a = cdb_data;
          else begin m_ha = 0; m_ta = rf1_tag; end
        end
        m_hb = 1; m_b = ctl_i.src2_data;
        if (ctl_i.src2_valid) begin
          m_b = 0;
          if (rf2_ready) m_b = rf2_data;
          else if (cdb_valid && cdb_tag == rf2_tag) m_b = cdb_data;
          else begin m_hb = 0; m_tb = rf2_tag; end
        end
      end
    end else if (m_ha && m_hb) begin
      if (fu_ready) m_busy = 0;
    end else begin
      hit_a = !m_ha && cdb_valid && cdb_tag == m_ta;
      hit_b = !m_hb && cdb_valid && cdb_tag == m_tb;
      if (hit_a) begin m_ha = 1; m_a = cdb_data; end
      if (hit_b) begin m_hb = 1; m_b = cdb_data; end
    end
  endtask

  task automatic check_dut();
    bit mv;
    mv = m_busy && m_ha && m_hb;
    chk("res_empty", res_empty, !m_busy);
    chk("fu_valid", fu_valid, mv);
    if (mv) begin
      chk("fu_a", fu_a, m_a);
      chk("fu_b", fu_b, m_b);
      chk("fu_tag", fu_tag, m_tag);
      chk("fu_op", fu_op, m_ctl.op);
      chk("fu_funct3", fu_funct3, m_ctl.funct3);
      chk("fu_funct7", fu_funct7, m_ctl.funct7);
    end
  endtask

  task automatic step();
    if (load && !rst && !flush) chk("load_proto", res_empty, 1'b1);
    @(posedge clk);
    model_update();
    #1;
    check_dut();
  endtask

  initial begin
    idle_in();
    rst = 1;
    step(); step();
    chk("rst_a", fu_a, 0);
    chk("rst_b", fu_b, 0);
    chk("rst_tag", fu_tag, 0);
    idle_in();

    // 1: both ready at load
    load = 1; rob_tag_i = 3'd1;
    ctl_i.op = ALU_ADD; ctl_i.src1_valid = 1; ctl_i.src2_valid = 0;
    ctl_i.src2_data = 32'd7; ctl_i.funct3 = 3'd0;
    rf1_ready = 1; rf1_data = 32'd5;
    step();
    chk("t1_valid", fu_valid, 1);
    chk("t1_a", fu_a, 32'd5);
    chk("t1_b", fu_b, 32'd7);
    chk("t1_empty", res_empty, 0);
    idle_in(); fu_ready = 1;
    step();
    chk("t1_free", res_empty, 1);
    idle_in();

    // 2: pending on tag 3, non-matching broadcast first
    load = 1; rob_tag_i = 3'd2;
    ctl_i.op = ALU_SUB; ctl_i.src1_valid = 1; ctl_i.src2_valid = 1;
    rf1_tag = 3'd3; rf2_ready = 1; rf2_data = 32'd9;
    step();
    idle_in(); cdb_valid = 1; cdb_tag = 3'd2; cdb_data = 32'h55;
    step();
    chk("t2_nocap", fu_valid, 0);
    idle_in();
    step();
    cdb_valid = 1; cdb_tag = 3'd3; cdb_data = 32'h11;
    step();
    chk("t2_valid", fu_valid, 1);
    chk("t2_a", fu_a, 32'h11);
    chk("t2_b", fu_b, 32'd9);
    idle_in(); fu_ready = 1;
    step();
    idle_in();

    // 3: load-cycle bypass
    load = 1; rob_tag_i = 3'd4;
    ctl_i.src1_valid = 1; ctl_i.src2_valid = 0; ctl_i.src2_data = 32'd1;
    rf1_tag = 3'd4; cdb_valid = 1; cdb_tag = 3'd4; cdb_data = 32'hAA;
    step();
    chk("t3_valid", fu_valid, 1);
    chk("t3_a", fu_a, 32'hAA);
    idle_in(); fu_ready = 1;
    step();
    idle_in();

    // 4: both operands wake on one broadcast
    load = 1; rob_tag_i = 3'd5;
    ctl_i.src1_valid = 1; ctl_i.src2_valid = 1;
    rf1_tag = 3'd5; rf2_tag = 3'd5;
    step();
    idle_in(); cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 32'h20;
    step();
    chk("t4_a", fu_a, 32'h20);
    chk("t4_b", fu_b, 32'h20);
    idle_in(); fu_ready = 1;
    step();
    idle_in();

    // 5: stall in READY with an aliasing broadcast
    load = 1; rob_tag_i = 3'd6;
    ctl_i.src1_valid = 1; ctl_i.src2_valid = 0; ctl_i.src2_data = 32'd2;
    rf1_tag = 3'd6;
    step();
    idle_in(); cdb_valid = 1; cdb_tag = 3'd6; cdb_data = 32'h33;
    step();
    for (int i = 0; i < 3; i++) begin
      cdb_data = 32'h99;
      step();
      chk("t5_hold", fu_a, 32'h33);
    end
    idle_in(); fu_ready = 1;
    step();
    chk("t5_free", res_empty, 1);
    idle_in();

    // 6: flush in WAIT, flush in READY, reset during load
    load = 1; ctl_i.src1_valid = 1; rf1_tag = 3'd7;
    step();
    idle_in(); flush = 1;
    step();
    chk("t6_wait", res_empty, 1);
    idle_in();
    load = 1; ctl_i.src2_data = 32'd3; rf1_ready = 1; ctl_i.src1_valid = 1;
    step();
    idle_in(); flush = 1; fu_ready = 1;
    step();
    chk("t6_ready", fu_valid, 0);
    idle_in();
    load = 1; rst = 1; rf1_ready = 1;
    step();
    chk("t6_rst", res_empty, 1);
    idle_in();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(99) == 0);
      flush = ($urandom_range(99) < 3);
      load  = !m_busy && $urandom_range(1);
      rob_tag_i = 3'($urandom);
      ctl_i.op = alu_op_t'($urandom_range(9));
      ctl_i.src1_valid = ($urandom_range(3) != 0);
      ctl_i.src2_valid = ($urandom_range(3) != 0);
      ctl_i.src2_data = $urandom;
      ctl_i.funct3 = 3'($urandom);
      ctl_i.funct7 = 1'($urandom);
      ctl_i.pc = $urandom;
      rf1_ready = ($urandom_range(9) < 4);
      rf2_ready = ($urandom_range(9) < 4);
      rf1_data = $urandom; rf2_data = $urandom;
      rf1_tag = 3'($urandom); rf2_tag = 3'($urandom);
      cdb_valid = 1'($urandom);
      cdb_tag = 3'($urandom);
      cdb_data = $urandom;
      fu_ready = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
